// File: rtl/mc_main_control_if.sv
// mc_main_control_if: control bus between the multi-cycle main control FSM and the datapath (slave = controller, master = datapath/bench)
interface mc_main_control_if #(
  parameter int OPW = 6,
  parameter int STW = 4
);
  logic [OPW-1:0] opcode;
  logic           zero;
  logic           mem_ready;
  logic           pc_write;
  logic           pc_write_cond;
  logic           i_or_d;
  logic           mem_read;
  logic           mem_write;
  logic           ir_write;
  logic           mem_to_reg;
  logic           reg_dst;
  logic           reg_write;
  logic           alu_src_a;
  logic [1:0]     alu_src_b;
  logic [1:0]     ALUOP;
  logic [1:0]     pc_source;
  logic [STW-1:0] state;
  logic           illegal_op;
  modport slave (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, ALUOP, pc_source, state, illegal_op
  );
  modport master (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, ALUOP, pc_source, state, illegal_op
  );
endinterface

// File: rtl/mc_main_control.sv
// mc_main_control: multi-cycle MIPS main control FSM (ports: clk, rst_n, bus = opcode/zero/mem_ready in, datapath controls/state/illegal_op out; optional ILLEGAL_OP_TRAP_EN traps unknown opcodes)
module mc_main_control #(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input logic clk,
  input logic rst_n,
  mc_main_control_if.slave bus
);
  localparam logic [STW-1:0] FETCH  = STW'(0);
  localparam logic [STW-1:0] DECODE = STW'(1);
  localparam logic [STW-1:0] MEMADR = STW'(2);
  localparam logic [STW-1:0] MEMRD  = STW'(3);
  localparam logic [STW-1:0] MEMWB  = STW'(4);
  localparam logic [STW-1:0] MEMWR  = STW'(5);
  localparam logic [STW-1:0] EXEC   = STW'(6);
  localparam logic [STW-1:0] ALUWB  = STW'(7);
  localparam logic [STW-1:0] BRANCH = STW'(8);
  localparam logic [STW-1:0] ADDIEX = STW'(9);
  localparam logic [STW-1:0] ADDIWB = STW'(10);
  localparam logic [STW-1:0] JUMP   = STW'(11);
  localparam logic [STW-1:0] TRAP   = STW'(12);
  localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
`ifdef ILLEGAL_OP_TRAP_EN
  localparam logic [STW-1:0] BAD_OP = TRAP;
`else
  localparam logic [STW-1:0] BAD_OP = FETCH;
`endif
  logic [STW-1:0] st, nx;
  logic [OPW-1:0] op;
  assign op = bus.opcode;
  assign bus.state = st;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= FETCH;
    else st <= nx;
  always_comb begin
    nx = FETCH;
    case (st)
      FETCH:  nx = bus.mem_ready ? DECODE : FETCH;
      DECODE: nx = (op == OP_LW || op == OP_SW) ? MEMADR :
                   op == OP_R    ? EXEC   :
                   op == OP_BEQ  ? BRANCH :
                   op == OP_J    ? JUMP   :
                   op == OP_ADDI ? ADDIEX : BAD_OP;
      MEMADR: nx = op == OP_SW ? MEMWR : MEMRD;
      MEMRD:  nx = bus.mem_ready ? MEMWB : MEMRD;
      MEMWR:  nx = bus.mem_ready ? FETCH : MEMWR;
      EXEC:   nx = ALUWB;
      ADDIEX: nx = ADDIWB;
`ifdef ILLEGAL_OP_TRAP_EN
      TRAP:   nx = TRAP;
`endif
      default: nx = FETCH;
    endcase
  end
  // Outputs are gated by rst_n so no enable can pulse while reset is held.
  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.ALUOP         = 2'b00;
    bus.pc_source     = 2'b00;
    bus.illegal_op    = 1'b0;
    if (rst_n)
      case (st)
        FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'b01;
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
        end
        DECODE: bus.alu_src_b = 2'b11;
        MEMADR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
        end
        MEMRD: begin
          bus.mem_read = 1'b1;
          bus.i_or_d   = 1'b1;
        end
        MEMWB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
        end
        MEMWR: begin
          bus.mem_write = 1'b1;
          bus.i_or_d    = 1'b1;
        end
        EXEC: begin
          bus.alu_src_a = 1'b1;
          bus.ALUOP     = 2'b10;
        end
        ALUWB: begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = 1'b1;
        end
        BRANCH: begin
          bus.alu_src_a     = 1'b1;
          bus.ALUOP         = 2'b01;
          bus.pc_write_cond = 1'b1;
          bus.pc_source     = 2'b01;
        end
        ADDIEX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
        end
        ADDIWB: bus.reg_write = 1'b1;
        JUMP: begin
          bus.pc_write  = 1'b1;
          bus.pc_source = 2'b10;
        end
`ifdef ILLEGAL_OP_TRAP_EN
        TRAP: bus.illegal_op = 1'b1;
`endif
        default: ;
      endcase
  end
endmodule

// File: tb/tb_mc_main_control.sv
// tb_mc_main_control: scoreboard bench for mc_main_control with randomized instruction streams and stalls
module tb_mc_main_control;
  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] o;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  int ps[$];
  logic pm[$];
  mc_main_control_if bus ();
  mc_main_control dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [16:0] model(int s, logic mr);
    logic pw = 0, pwc = 0, iod = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rd = 0, rw = 0, asa = 0, il = 0;
    logic [1:0] asb = 0, aop = 0, psrc = 0;
    case (s)
      0:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iod = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
      9:  begin asa = 1; asb = 2'b10; end
      10: rw = 1;
      11: begin pw = 1; psrc = 2'b10; end
      12: il = 1;
      default: ;
    endcase
    return {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, psrc, il};
  endfunction
  function automatic logic [16:0] actual();
    return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
            bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.ALUOP,
            bus.pc_source, bus.illegal_op};
  endfunction
  function automatic bit legal(logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
  endfunction
  task automatic push_cyc(int s, logic mr);
    ps.push_back(s);
    pm.push_back(mr);
  endtask
  // Expected cycle sequence of one instruction, derived from its class and the chosen memory stalls.
  task automatic build(logic [5:0] op, int fk, int mk);
    repeat (fk) push_cyc(0, 1'b0);
    push_cyc(0, 1'b1);
    push_cyc(1, 1'($urandom));
    case (op)
      6'b100011: begin
        push_cyc(2, 1'($urandom));
        repeat (mk) push_cyc(3, 1'b0);
        push_cyc(3, 1'b1);
        push_cyc(4, 1'($urandom));
      end
      6'b101011: begin
        push_cyc(2, 1'($urandom));
        repeat (mk) push_cyc(5, 1'b0);
        push_cyc(5, 1'b1);
      end
      6'b000000: begin push_cyc(6, 1'($urandom)); push_cyc(7, 1'($urandom)); end
      6'b000100: push_cyc(8, 1'($urandom));
      6'b000010: push_cyc(11, 1'($urandom));
      6'b001000: begin push_cyc(9, 1'($urandom)); push_cyc(10, 1'($urandom)); end
      default: begin
`ifdef ILLEGAL_OP_TRAP_EN
        repeat (10) push_cyc(12, 1'($urandom));
`endif
      end
    endcase
  endtask
  // Plays the planned cycles; entered and left at posedge+1.
  task automatic run(logic [5:0] op);
    bus.opcode = op;
    for (int i = 0; i < ps.size(); i++) begin
      bus.mem_ready = pm[i];
      bus.zero = 1'($urandom);
      q.push_back({4'(ps[i]), model(ps[i], pm[i])});
      @(posedge clk);
      #1;
    end
    ps.delete();
    pm.delete();
  endtask
  task automatic chk(string name, logic [20:0] act, logic [20:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && q.size() > 0) begin
      e = q.pop_front();
      chk("cycle", {bus.state, actual()}, e);
      chk("onehot", 21'({bus.mem_read & bus.mem_write, bus.reg_write & bus.mem_write}), 21'd0);
    end
  end
  initial begin
    logic [5:0] op;
    rst_n = 1'b0;
    bus.opcode = 6'd0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", {bus.state, actual()}, 21'd0);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    build(6'b000000, 0, 0);
    run(6'b000000);
    build(6'b100011, 0, 2);
    run(6'b100011);
    build(6'b101011, 1, 1);
    run(6'b101011);
    build(6'b000100, 0, 0);
    run(6'b000100);
    build(6'b000010, 0, 0);
    run(6'b000010);
    build(6'b001000, 2, 0);
    run(6'b001000);
    push_cyc(0, 1'b1);
    push_cyc(1, 1'b1);
    run(6'b000000);
    bus.mem_ready = 1'b1;
    #2;
    chk("exec_before_reset", 21'(bus.state), 21'd6);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {bus.state, actual()}, 21'd0);
    @(posedge clk);
    #1;
    chk("reset_clocked", {bus.state, actual()}, 21'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("first_fetch", {bus.state, actual()}, {4'd0, model(0, 1'b1)});
    @(posedge clk);
    #1;
    push_cyc(1, 1'b1);
    push_cyc(6, 1'b1);
    push_cyc(7, 1'b1);
    run(6'b000000);
    for (int n = 0; n < 60; n++) begin
      op = 6'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 5))
          0: op = 6'b000000;
          1: op = 6'b100011;
          2: op = 6'b101011;
          3: op = 6'b000100;
          4: op = 6'b000010;
          default: op = 6'b001000;
        endcase
      end
`ifdef ILLEGAL_OP_TRAP_EN
      if (!legal(op)) op = 6'b000000;
`endif
      build(op, $urandom_range(0, 2), $urandom_range(0, 3));
      run(op);
    end
    build(6'b111111, 0, 0);
`ifndef ILLEGAL_OP_TRAP_EN
    push_cyc(0, 1'b0);
`endif
    run(6'b111111);
    repeat (2) @(posedge clk);
    chk("queue_drained", 21'(q.size()), 21'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
